bridge_gate_ctrl: RTL and testbench



---
 rtl/bridge_gate_ctrl.sv | 147 ++++++++++++++
 tb/tb_bridge_gate_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_gate_ctrl.sv
// rtl/bridge_gate_ctrl.sv - DRSSTC bridge gate driver with dead time, max on-time and OCD shutdown
module bridge_gate_ctrl #(
    parameter int CLK_MHZ   = 100,
    parameter int DEAD_NS   = 100,
    parameter int MAX_ON_US = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic phase,
    input  logic en,
    input  logic ocd,
    output logic hi,
    output logic lo,
    output logic active,
    output logic fault
);
    localparam int DEAD_CYC   = CLK_MHZ * DEAD_NS / 1000;
    localparam int MAX_ON_CYC = CLK_MHZ * MAX_ON_US;
    localparam int ON_W       = $clog2(MAX_ON_CYC + 1);
    localparam int DEAD_W     = $clog2(DEAD_CYC + 1);

    generate
        if (DEAD_CYC < 1) begin : g_dead_chk
            $error("bridge_gate_ctrl: dead time must be at least one clock cycle");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, ARM, RUN, STOP, LOCK} state_t;

    logic [1:0] ph_sync, en_sync, ocd_sync;
    logic       ph_d;
    logic       ph_s, en_s, ocd_s, ph_edge;

    state_t            state, state_nxt;
    logic [DEAD_W-1:0] dead_cnt, dead_nxt;
    logic [ON_W-1:0]   on_cnt, on_nxt;
    logic              hi_nxt, lo_nxt, fault_nxt, active_nxt;

    assign ph_s    = ph_sync[1];
    assign en_s    = en_sync[1];
    assign ocd_s   = ocd_sync[1];
    assign ph_edge = ph_s ^ ph_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_sync  <= 2'b00;
            en_sync  <= 2'b00;
            ocd_sync <= 2'b00;
            ph_d     <= 1'b0;
        end else begin
            ph_sync  <= {ph_sync[0], phase};
            en_sync  <= {en_sync[0], en};
            ocd_sync <= {ocd_sync[0], ocd};
            ph_d     <= ph_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dead_cnt <= '0;
            on_cnt   <= '0;
            hi       <= 1'b0;
            lo       <= 1'b0;
            active   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_nxt;
            on_cnt   <= on_nxt;
            hi       <= hi_nxt;
            lo       <= lo_nxt;
            active   <= active_nxt;
            fault    <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dead_nxt  = dead_cnt;
        on_nxt    = on_cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        fault_nxt = fault;

        // Shared drive rule for RUN and STOP: every edge opens a fresh dead gap.
        if (state == RUN || state == STOP) begin
            if (ph_edge) begin
                hi_nxt   = 1'b0;
                lo_nxt   = 1'b0;
                dead_nxt = DEAD_W'(DEAD_CYC);
            end else if (dead_cnt != '0) begin
                dead_nxt = dead_cnt - DEAD_W'(1);
                if (dead_cnt == DEAD_W'(1)) begin
                    hi_nxt = ph_s;
                    lo_nxt = !ph_s;
                end
            end
        end

        case (state)
            IDLE: begin
                hi_nxt = 1'b0;
                lo_nxt = 1'b0;
                if (en_s) state_nxt = ARM;
            end
            ARM: begin
                hi_nxt = 1'b0;
                lo_nxt = 1'b0;
                if (!en_s) begin
                    state_nxt = IDLE;
                end else if (ph_edge) begin
                    state_nxt = RUN;
                    dead_nxt  = DEAD_W'(DEAD_CYC);
                    on_nxt    = '0;
                end
            end
            RUN: begin
                on_nxt = on_cnt + ON_W'(1);
                if (ocd_s) begin
                    state_nxt = STOP;
                    fault_nxt = 1'b1;
                end else if (!en_s || on_cnt == ON_W'(MAX_ON_CYC - 1)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (ph_edge) state_nxt = LOCK;
            end
            LOCK: begin
                hi_nxt = 1'b0;
                lo_nxt = 1'b0;
                if (!en_s) begin
                    state_nxt = IDLE;
                    fault_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                hi_nxt    = 1'b0;
                lo_nxt    = 1'b0;
            end
        endcase

        active_nxt = (state_nxt == RUN) || (state_nxt == STOP);
    end
endmodule

// File: tb/tb_bridge_gate_ctrl.sv
// tb/tb_bridge_gate_ctrl.sv - directed self-checking bench for bridge_gate_ctrl
module tb_bridge_gate_ctrl;
    logic clk = 1'b0;
    logic rst_n, phase, en, ocd;
    logic hi, lo, active, fault;
    logic phase2, en2, ocd2;
    logic hi2, lo2, active2, fault2;
    int checks = 0;
    int errors = 0;

    wire [3:0] o1 = {hi, lo, active, fault};
    wire [3:0] o2 = {hi2, lo2, active2, fault2};

    always #5 clk = ~clk;

    bridge_gate_ctrl dut (
        .clk(clk), .rst_n(rst_n), .phase(phase), .en(en), .ocd(ocd),
        .hi(hi), .lo(lo), .active(active), .fault(fault)
    );

    // Short max on-time instance: 200 RUN cycles
    bridge_gate_ctrl #(.MAX_ON_US(2)) dut_m (
        .clk(clk), .rst_n(rst_n), .phase(phase2), .en(en2), .ocd(ocd2),
        .hi(hi2), .lo(lo2), .active(active2), .fault(fault2)
    );

    always @(negedge clk) begin
        checks++;
        if ((hi && lo) || (hi2 && lo2)) begin
            errors++;
            $display("FAIL overlap: hi=%b lo=%b hi2=%b lo2=%b required never both 1", hi, lo, hi2, lo2);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; phase = 1'b0; en = 1'b0; ocd = 1'b0;
        phase2 = 1'b0; en2 = 1'b0; ocd2 = 1'b0;
        tick(3);
        checks++;
        if (o1 !== 4'b0000 || o2 !== 4'b0000) begin
            errors++; $display("FAIL reset_hold: o1=%b o2=%b required 0000", o1, o2);
        end
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (o1 !== 4'b0000) begin
            errors++; $display("FAIL reset_release: o1=%b required 0000", o1);
        end
    endtask

    task automatic end_burst;
        en = 1'b0;
        tick(5);
        phase = ~phase;
        tick(3);
        checks++;
        if (o1 !== 4'b0000) begin
            errors++; $display("FAIL end_burst_cut: o1=%b required 0000", o1);
        end
        tick(3);
    endtask

    task automatic test_normal_burst;
        en = 1'b1;
        tick(5);
        checks++;
        if (o1 !== 4'b0000) begin
            errors++; $display("FAIL normal_arm: o1=%b required 0000", o1);
        end
        for (int k = 0; k < 6; k++) begin
            phase = ~phase;
            if (k > 0) begin
                tick(2);
                checks++;
                if (o1 !== {~phase, phase, 2'b10}) begin
                    errors++; $display("FAIL normal_old_side k=%0d: o1=%b required %b", k, o1, {~phase, phase, 2'b10});
                end
                tick(10);
            end else begin
                tick(12);
            end
            checks++;
            if (o1 !== 4'b0010) begin
                errors++; $display("FAIL normal_dead k=%0d: o1=%b required 0010", k, o1);
            end
            tick(1);
            checks++;
            if (o1 !== {phase, ~phase, 2'b10}) begin
                errors++; $display("FAIL normal_new_side k=%0d: o1=%b required %b", k, o1, {phase, ~phase, 2'b10});
            end
            if (k < 5) tick(487);
        end
        tick(187);
        en = 1'b0;
        tick(5);
        checks++;
        if (o1 !== {phase, ~phase, 2'b10}) begin
            errors++; $display("FAIL normal_stop_hold: o1=%b required %b", o1, {phase, ~phase, 2'b10});
        end
        tick(295);
        phase = ~phase;
        tick(2);
        checks++;
        if (o1 !== {~phase, phase, 2'b10}) begin
            errors++; $display("FAIL normal_stop_pre_edge: o1=%b required %b", o1, {~phase, phase, 2'b10});
        end
        tick(1);
        checks++;
        if (o1 !== 4'b0000) begin
            errors++; $display("FAIL normal_cut: o1=%b required 0000", o1);
        end
        tick(13);
        checks++;
        if (o1 !== 4'b0000) begin
            errors++; $display("FAIL normal_no_new_side: o1=%b required 0000", o1);
        end
        tick(2);
    endtask

    task automatic test_dead_restart;
        en = 1'b1;
        tick(5);
        phase = ~phase;
        tick(13);
        tick(50);
        phase = ~phase;
        tick(4);
        phase = ~phase;
        tick(9);
        checks++;
        if (o1 !== 4'b0010) begin
            errors++; $display("FAIL restart_no_early_side: o1=%b required 0010", o1);
        end
        tick(3);
        checks++;
        if (o1 !== 4'b0010) begin
            errors++; $display("FAIL restart_dead_end: o1=%b required 0010", o1);
        end
        tick(1);
        checks++;
        if (o1 !== {phase, ~phase, 2'b10}) begin
            errors++; $display("FAIL restart_side: o1=%b required %b", o1, {phase, ~phase, 2'b10});
        end
        end_burst();
    endtask

    task automatic test_ocd;
        en = 1'b1;
        tick(5);
        phase = ~phase;
        tick(113);
        ocd = 1'b1;
        tick(3);
        ocd = 1'b0;
        checks++;
        if (o1 !== {phase, ~phase, 2'b11}) begin
            errors++; $display("FAIL ocd_fault_set: o1=%b required %b", o1, {phase, ~phase, 2'b11});
        end
        tick(200);
        phase = ~phase;
        tick(2);
        checks++;
        if (o1 !== {~phase, phase, 2'b11}) begin
            errors++; $display("FAIL ocd_hold_half: o1=%b required %b", o1, {~phase, phase, 2'b11});
        end
        tick(1);
        checks++;
        if (o1 !== 4'b0001) begin
            errors++; $display("FAIL ocd_cut: o1=%b required 0001", o1);
        end
        tick(13);
        phase = ~phase;
        tick(20);
        checks++;
        if (o1 !== 4'b0001) begin
            errors++; $display("FAIL ocd_lock_no_restart: o1=%b required 0001", o1);
        end
        en = 1'b0;
        tick(2);
        checks++;
        if (o1 !== 4'b0001) begin
            errors++; $display("FAIL ocd_fault_early_clear: o1=%b required 0001", o1);
        end
        tick(1);
        checks++;
        if (o1 !== 4'b0000) begin
            errors++; $display("FAIL ocd_fault_clear: o1=%b required 0000", o1);
        end
    endtask

    task automatic test_max_on;
        en2 = 1'b1;
        tick(5);
        phase2 = ~phase2;
        tick(13);
        checks++;
        if (o2 !== {phase2, ~phase2, 2'b10}) begin
            errors++; $display("FAIL maxon_side: o2=%b required %b", o2, {phase2, ~phase2, 2'b10});
        end
        tick(187);
        phase2 = ~phase2;
        tick(3);
        checks++;
        if (o2 !== 4'b0010) begin
            errors++; $display("FAIL maxon_last_run_edge: o2=%b required 0010", o2);
        end
        tick(10);
        checks++;
        if (o2 !== {phase2, ~phase2, 2'b10}) begin
            errors++; $display("FAIL maxon_stop_side: o2=%b required %b", o2, {phase2, ~phase2, 2'b10});
        end
        tick(50);
        phase2 = ~phase2;
        tick(3);
        tick(30);
        checks++;
        if (o2 !== 4'b0000) begin
            errors++; $display("FAIL maxon_lock_wait: o2=%b required 0000", o2);
        end
        en2 = 1'b0;
        tick(3);
        en2 = 1'b1;
        tick(5);
        phase2 = ~phase2;
        tick(201);
        phase2 = ~phase2;
        tick(2);
        checks++;
        if (o2 !== {~phase2, phase2, 2'b10}) begin
            errors++; $display("FAIL maxon_stop_hold: o2=%b required %b", o2, {~phase2, phase2, 2'b10});
        end
        tick(1);
        checks++;
        if (o2 !== 4'b0000) begin
            errors++; $display("FAIL maxon_cut: o2=%b required 0000", o2);
        end
        en2 = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_mid_burst;
        en = 1'b1;
        tick(5);
        phase = ~phase;
        tick(113);
        ocd = 1'b1;
        tick(3);
        ocd = 1'b0;
        checks++;
        if (o1 !== {phase, ~phase, 2'b11}) begin
            errors++; $display("FAIL rstmid_pre: o1=%b required %b", o1, {phase, ~phase, 2'b11});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o1 !== 4'b0000) begin
            errors++; $display("FAIL rstmid_async: o1=%b required 0000", o1);
        end
        en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        phase = ~phase;
        tick(20);
        checks++;
        if (o1 !== 4'b0000) begin
            errors++; $display("FAIL rstmid_no_output: o1=%b required 0000", o1);
        end
        en = 1'b1;
        tick(5);
        phase = ~phase;
        tick(13);
        checks++;
        if (o1 !== {phase, ~phase, 2'b10}) begin
            errors++; $display("FAIL rstmid_rearm: o1=%b required %b", o1, {phase, ~phase, 2'b10});
        end
        end_burst();
    endtask

    task automatic test_idle_noise;
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ocd = ~ocd;
            phase = ~phase;
            tick(7);
            checks++;
            if (o1 !== 4'b0000) begin
                errors++; $display("FAIL idle_noise i=%0d: o1=%b required 0000", i, o1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_burst();
        test_dead_restart();
        test_ocd();
        test_max_on();
        test_reset_mid_burst();
        test_idle_noise();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
